// File: rtl/adpll_tx_ser.sv
// rtl/adpll_tx_ser.sv - bus-loaded byte FIFO serialized LSB-first onto data_mod for adpll_ctr.
// Optional output whitening (7-bit LFSR x^7+x^4+1) is compiled in with `define ADPLL_TX_WHITEN_EN.
module adpll_tx_ser #(
  parameter int SYM_CYCLES = 32,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [1:0] address,
  input  logic [7:0] wdata,
  input  logic       wstrb,
  output logic [7:0] rdata,
  output logic       ready,
  input  logic       channel_lock,
  output logic       data_mod,
  output logic       tx_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = $clog2(SYM_CYCLES);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nx;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full;
  logic               push, pop, push_req, ovf_set;
  logic               bus_req, wr_acc, ctrl_wr, flag_clr;
  logic               enable, overflow, abort, abort_set;
  logic               load, sym_wrap, bit_last;
  logic [7:0]         shreg;
  logic [2:0]         bit_cnt;
  logic [SW-1:0]      sym_cnt;
  logic [7:0]         rd_mux;
  logic               whiten_bit;

  // A request is serviced once: the ready cycle itself must not re-trigger it.
  assign bus_req  = valid & ~ready;
  assign wr_acc   = bus_req & wstrb;
  assign ctrl_wr  = wr_acc & (address == 2'd1);
  assign flag_clr = ctrl_wr & wdata[1];
  assign push_req = wr_acc & (address == 2'd0);
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign empty    = (count == '0);
  assign full     = (count == {1'b1, {FIFO_AW{1'b0}}});
  assign sym_wrap = (sym_cnt == SYM_LAST);
  assign bit_last = (bit_cnt == 3'd7);
  assign tx_busy  = (state == SHIFT);
  assign data_mod = (state == SHIFT) & (shreg[0] ^ whiten_bit);

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    load      = 1'b0;
    abort_set = 1'b0;
    case (state)
      IDLE: begin
        if (enable && channel_lock && !empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        // Lock loss wins over everything, including a byte boundary.
        if (!channel_lock) begin
          abort_set = 1'b1;
          state_nx  = IDLE;
        end else if (sym_wrap && bit_last) begin
          if (enable && !empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sym_cnt <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        shreg   <= mem[rd_ptr];
        bit_cnt <= '0;
        sym_cnt <= '0;
      end else if (state == SHIFT) begin
        if (sym_wrap) begin
          sym_cnt <= '0;
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= {1'b0, shreg[7:1]};
        end else begin
          sym_cnt <= sym_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ADPLL_TX_WHITEN_EN
  logic [6:0] seed, lfsr;

  assign whiten_bit = lfsr[6];

  // Seed only on a fresh start; back-to-back bytes keep the running sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed <= 7'h7F;
      lfsr <= '0;
    end else begin
      if (wr_acc && address == 2'd3) seed <= wdata[6:0];
      if (state == IDLE) begin
        if (load) lfsr <= seed;
      end else if (sym_wrap) begin
        lfsr <= {lfsr[5:4], lfsr[3] ^ lfsr[6], lfsr[2:0], lfsr[6]};
      end
    end
  end
`else
  assign whiten_bit = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd1: rd_mux = {7'b0, enable};
      2'd2: rd_mux = {3'b0, abort, overflow, full, empty, tx_busy};
`ifdef ADPLL_TX_WHITEN_EN
      2'd3: rd_mux = {1'b0, seed};
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      rdata    <= '0;
      enable   <= 1'b0;
      overflow <= 1'b0;
      abort    <= 1'b0;
    end else begin
      ready <= bus_req;
      rdata <= (bus_req && !wstrb) ? rd_mux : 8'h00;
      if (ctrl_wr) enable <= wdata[0];
      // A new event in the clearing cycle is kept rather than lost.
      if (ovf_set)       overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
      if (abort_set)     abort <= 1'b1;
      else if (flag_clr) abort <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adpll_tx_ser.sv
// tb/tb_adpll_tx_ser.sv - self-checking bench for adpll_tx_ser against a bit-stream model.
module tb_adpll_tx_ser;

  localparam int SYM = 32;
`ifdef ADPLL_TX_WHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  typedef logic [7:0] byteq_t[$];

  logic       clk = 1'b0;
  logic       rst, valid, wstrb, channel_lock;
  logic [1:0] address;
  logic [7:0] wdata, rdata;
  logic       ready, data_mod, tx_busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] seed_model = 7'h7F;

  adpll_tx_ser #(.SYM_CYCLES(SYM), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .channel_lock(channel_lock),
    .data_mod(data_mod), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] lfsr_step(input logic [6:0] l);
    logic [6:0] n;
    n = {l[5:0], l[6]};
    if (l[6]) n = n ^ 7'h10;
    return n;
  endfunction

  task automatic bus_op(input logic [1:0] a, input logic we, input logic [7:0] d,
                        output logic [7:0] rd);
    int t = 0;
    @(negedge clk);
    valid = 1'b1; address = a; wstrb = we; wdata = d;
    do begin
      @(negedge clk);
      t++;
    end while (!ready && t < 20);
    n_checks++;
    if (ready !== 1'b1 || t != 1) begin
      n_fail++;
      $display("FAIL bus_ready addr=%0d: ready=%b after %0d cycles, required 1 after 1", a, ready, t);
    end
    rd = rdata;
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus_op(a, 1'b1, d, dummy);
  endtask

  task automatic check_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    logic [7:0] rd;
    bus_op(a, 1'b0, 8'h00, rd);
    n_checks++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL %s: rdata=%h required %h", name, rd, exp);
    end
  endtask

  task automatic lock_low();
    @(negedge clk);
    channel_lock = 1'b0;
  endtask

  // Raises channel_lock (FSM idle, enable set, bytes queued) and checks every
  // cycle of the resulting stream, then that the line returns to idle.
  task automatic check_stream(input byteq_t bytes, input string name);
    logic [6:0] l;
    logic       expb;
    int         bad;
    l = WHITEN ? seed_model : 7'h00;
    @(negedge clk);
    channel_lock = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: tx_busy=%b required 1", name, tx_busy);
    end
    for (int k = 0; k < bytes.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        expb = bytes[k][i] ^ l[6];
        bad  = 0;
        repeat (SYM) begin
          if (data_mod !== expb) bad++;
          @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL %s byte%0d bit%0d: %0d of %0d cycles wrong, required data_mod=%b",
                   name, k, i, bad, SYM, expb);
        end
        l = lfsr_step(l);
      end
    end
    n_checks++;
    if (tx_busy !== 1'b0 || data_mod !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: tx_busy=%b data_mod=%b required 0 0", name, tx_busy, data_mod);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    rst = 1'b1; valid = 1'b0; wstrb = 1'b0; address = 2'd0; wdata = 8'h00; channel_lock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (data_mod !== 1'b0 || tx_busy !== 1'b0 || ready !== 1'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: data_mod=%b tx_busy=%b ready=%b rdata=%h required 0 0 0 00",
               data_mod, tx_busy, ready, rdata);
    end
    bus_op(2'd2, 1'b0, 8'h00, rd);
    n_checks++;
    if (rd !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_status: rdata=%h required 02", rd);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL ready_pulse: ready=%b rdata=%h required 0 00", ready, rdata);
    end
    check_read(2'd1, 8'h00, "reset_ctrl");
    check_read(2'd3, WHITEN ? 8'h7F : 8'h00, "reset_seed");
    check_read(2'd0, 8'h00, "data_read");
  endtask

  task automatic test_single();
    byteq_t q;
    q = {8'hA5};
    lock_low();
    bus_write(2'd1, 8'h01);
    bus_write(2'd0, 8'hA5);
    check_stream(q, "single_a5");
  endtask

  task automatic test_back_to_back();
    byteq_t q;
    q = {8'h01, 8'h80};
    lock_low();
    bus_write(2'd0, 8'h01);
    bus_write(2'd0, 8'h80);
    check_stream(q, "b2b");
  endtask

  task automatic test_overflow();
    byteq_t q;
    logic [7:0] b;
    lock_low();
    bus_write(2'd1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) q.push_back(b);
      bus_write(2'd0, b);
    end
    check_read(2'd2, 8'h0C, "ovf_status");
    bus_write(2'd1, 8'h02);
    check_read(2'd2, 8'h04, "ovf_cleared");
    bus_write(2'd1, 8'h01);
    check_stream(q, "ovf_drain");
  endtask

  task automatic test_abort();
    byteq_t q;
    logic [7:0] b1, b2;
    logic [6:0] l;
    b1 = 8'($urandom); b2 = 8'($urandom);
    q = {b2};
    l = WHITEN ? seed_model : 7'h00;
    for (int i = 0; i < 3; i++) l = lfsr_step(l);
    lock_low();
    bus_write(2'd0, b1);
    bus_write(2'd0, b2);
    @(negedge clk);
    channel_lock = 1'b1;
    repeat (3 * SYM + 6) @(negedge clk);
    n_checks++;
    if (data_mod !== (b1[3] ^ l[6]) || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_bit3: data_mod=%b tx_busy=%b required %b 1", data_mod, tx_busy, b1[3] ^ l[6]);
    end
    channel_lock = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_mod !== 1'b0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: data_mod=%b tx_busy=%b required 0 0", data_mod, tx_busy);
    end
    check_read(2'd2, 8'h10, "abort_status");
    bus_write(2'd1, 8'h03);
    check_read(2'd2, 8'h00, "abort_cleared");
    check_stream(q, "abort_resume");
  endtask

`ifdef ADPLL_TX_WHITEN_EN
  task automatic test_whiten();
    byteq_t q;
    lock_low();
    bus_write(2'd3, 8'h01);
    seed_model = 7'h01;
    check_read(2'd3, 8'h01, "seed_read");
    q = {8'h00};
    bus_write(2'd0, 8'h00);
    check_stream(q, "whiten_seed1");
    lock_low();
    bus_write(2'd3, 8'h00);
    seed_model = 7'h00;
    q = {8'h5A};
    bus_write(2'd0, 8'h5A);
    check_stream(q, "whiten_seed0");
  endtask
`endif

  task automatic test_random();
    byteq_t q;
    int n;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      q.delete();
      n = $urandom_range(1, 4);
      lock_low();
      if (WHITEN) begin
        seed_model = 7'($urandom);
        bus_write(2'd3, {1'b0, seed_model});
      end
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(2'd0, b);
      end
      check_stream(q, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_abort();
`ifdef ADPLL_TX_WHITEN_EN
    test_whiten();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
